// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 opcodes, IF/ID control encodings and fetch-stage state enum
package riscv_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] CTR_NORMAL = 2'b00;
    localparam logic [1:0] CTR_STALL  = 2'b01;
    localparam logic [1:0] CTR_BUBBLE = 2'b10;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } if_state_e;

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction-memory fetch port between if_stage (master) and imem (slave)
interface if_stage_if;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_rvalid_i,
        output imem_rdata_i
    );

endinterface

// File: rtl/if_next_pc.sv
// rtl/if_next_pc.sv - sequential next-PC; IF_STATIC_PRED_EN adds backward-branch/JAL static prediction
module if_next_pc (
    input  logic [31:0] pc,
`ifdef IF_STATIC_PRED_EN
    input  logic [31:0] instr,
`endif
    output logic [31:0] next_pc,
    output logic        br_pred
);

`ifdef IF_STATIC_PRED_EN
    import riscv_pkg::*;

    // backward conditional branches are predicted taken, JAL is always taken
    always_comb begin
        next_pc = pc + 32'd4;
        br_pred = 1'b0;
        if (instr[6:0] == OPC_BRANCH && instr[31]) begin
            next_pc = pc + imm_b(instr);
            br_pred = 1'b1;
        end else if (instr[6:0] == OPC_JAL) begin
            next_pc = pc + imm_j(instr);
            br_pred = 1'b1;
        end
    end
`else
    assign next_pc = pc + 32'd4;
    assign br_pred = 1'b0;
`endif

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32 fetch stage, one outstanding imem request; IF_STATIC_PRED_EN enables static prediction
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    if_stage_if.master  imem,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [1:0]  ifid_ctr_o,
    output logic        br_pred_o
);

    if_state_e   state_q;
    logic [31:0] pc_q;
    logic [31:0] buf_q;
    logic        kill_q;

    logic [31:0] instr_sel;
    logic [31:0] next_pc;
    logic        pred;

    // the word handed to IF/ID comes straight from memory in WAIT, from the stall buffer in HOLD
    assign instr_sel = (state_q == S_HOLD) ? buf_q : imem.imem_rdata_i;

    if_next_pc u_next_pc (
        .pc      (pc_q),
`ifdef IF_STATIC_PRED_EN
        .instr   (instr_sel),
`endif
        .next_pc (next_pc),
        .br_pred (pred)
    );

    always_comb begin
        imem.imem_req_o  = 1'b0;
        imem.imem_addr_o = pc_q;
        ifid_ctr_o       = CTR_BUBBLE;
        if (n_rst && !redirect_i) begin
            case (state_q)
                S_REQ: imem.imem_req_o = 1'b1;
                S_WAIT: begin
                    if (imem.imem_rvalid_i && !kill_q) begin
                        if (stall_i) begin
                            ifid_ctr_o = CTR_STALL;
                        end else begin
                            // back-to-back fetch keeps one instruction per cycle at 1-cycle latency
                            ifid_ctr_o       = CTR_NORMAL;
                            imem.imem_req_o  = 1'b1;
                            imem.imem_addr_o = next_pc;
                        end
                    end
                end
                S_HOLD: ifid_ctr_o = stall_i ? CTR_STALL : CTR_NORMAL;
                default: ifid_ctr_o = CTR_BUBBLE;
            endcase
        end
    end

    assign instr_o   = (ifid_ctr_o == CTR_NORMAL) ? instr_sel : 32'h0;
    assign pc_o      = pc_q;
    assign br_pred_o = (ifid_ctr_o == CTR_NORMAL) && pred;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            buf_q   <= 32'h0;
        end else if (redirect_i) begin
            pc_q  <= redirect_pc_i;
            buf_q <= 32'h0;
            // an in-flight request must be drained and dropped before refetching
            if (state_q == S_WAIT && !imem.imem_rvalid_i) begin
                kill_q <= 1'b1;
            end else begin
                state_q <= S_REQ;
                kill_q  <= 1'b0;
            end
        end else begin
            case (state_q)
                S_REQ: state_q <= S_WAIT;
                S_WAIT: begin
                    if (imem.imem_rvalid_i) begin
                        if (kill_q) begin
                            kill_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else if (stall_i) begin
                            buf_q   <= imem.imem_rdata_i;
                            state_q <= S_HOLD;
                        end else begin
                            pc_q <= next_pc;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        pc_q    <= next_pc;
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 stall_i  input  1  hazard unit holds the IF/ID register this cycle.
REQ-005 redirect_i  input  1  EX-stage branch/jump mispredict or redirect request.
REQ-006 redirect_pc_i  input  32  target PC for redirect.
REQ-007 imem_req_o  output  1  single-cycle fetch request strobe.
REQ-008 imem_addr_o  output  32  fetch address; valid while imem_req_o=1.
REQ-009 imem_rvalid_i  input  1  response valid; latency of at least 1 cycle, variable.
REQ-010 imem_rdata_i  input  32  fetched instruction word.
REQ-011 instr_o  output  32  instruction presented to the IF/ID register.
REQ-012 pc_o  output  32  PC of instr_o.
REQ-013 ifid_ctr_o  output  2  IF/ID control: 00 normal, 01 stall, 10 bubble.
REQ-014 br_pred_o  output  1  predicted-taken flag accompanying instr_o.

Function
REQ-015 The block SHALL hold at most one outstanding imem request; states REQ, WAIT, HOLD.
REQ-016 In REQ: imem_req_o=1, imem_addr_o=pc_q, ifid_ctr_o=10; next state WAIT.
REQ-017 In WAIT without imem_rvalid_i: imem_req_o=0, ifid_ctr_o=10; remain in WAIT.
REQ-018 In WAIT with imem_rvalid_i, kill_q=0, stall_i=0, no redirect: instr_o=imem_rdata_i, pc_o=pc_q, ifid_ctr_o=00; pc_q<=next_pc; imem_req_o=1 with imem_addr_o=next_pc in the same cycle; remain in WAIT (1 instruction/cycle at 1-cycle memory latency).
REQ-019 In WAIT with imem_rvalid_i, kill_q=0, stall_i=1: imem_rdata_i latched into buf_q, ifid_ctr_o=01; next state HOLD.
REQ-020 In HOLD while stall_i=1: ifid_ctr_o=01, no request, buf_q unchanged.
REQ-021 In HOLD with stall_i=0: instr_o=buf_q, pc_o=pc_q, ifid_ctr_o=00; pc_q<=next_pc; next state REQ.
REQ-022 redirect_i SHALL take priority over all other events: pc_q<=redirect_pc_i, ifid_ctr_o=10, buf_q discarded, no request that cycle.
REQ-023 Redirect in WAIT with no response this cycle: kill_q<=1, remain in WAIT; redirect coincident with imem_rvalid_i, or in REQ/HOLD: next state REQ.
REQ-024 Response with kill_q=1: discarded, kill_q<=0, ifid_ctr_o=10, next state REQ.
REQ-025 next_pc SHALL default to pc+4 (32-bit wrap-around, 32'hFFFF_FFFC+4=0), br_pred_o=0.
REQ-026 instr_o, pc_o and br_pred_o SHALL be don't-care whenever ifid_ctr_o is not 00.

Reset
REQ-027 n_rst low SHALL force pc_q=RESET_PC, state=REQ, kill_q=0, buf_q=0, imem_req_o=0, ifid_ctr_o=10, br_pred_o=0, asynchronously.
REQ-028 Reset during WAIT SHALL drop the outstanding request; an imem_rvalid_i arriving in the first cycle after release SHALL be ignored.
REQ-029 The first request SHALL issue in the first clock cycle after n_rst deasserts.

Configuration
REQ-030 Macro IF_STATIC_PRED_EN defined: for opcode 1100011 with instr[31]=1 (backward branch) next_pc=pc+B-immediate; for opcode 1101111 (JAL) next_pc=pc+J-immediate; br_pred_o=1 in both cases, else pc+4 and 0.
REQ-031 Macro undefined: next_pc=pc+4 always, br_pred_o tied 0, no predictor logic synthesised.

Structure
REQ-032 Shared package riscv_pkg SHALL hold OPC_BRANCH, OPC_JAL, CTR_NORMAL/CTR_STALL/CTR_BUBBLE encodings and the if_stage state enum.
REQ-033 Sub-module if_next_pc (pc, instr -> next_pc, br_pred) SHALL contain the REQ-025/030 logic.

Verification
REQ-034 Reset, RESET_PC=0x100, 1-cycle memory -> requests 0x100, 0x104, 0x108 on consecutive cycles; ctr 10 then 00 each cycle.
REQ-035 Response 0x00500093 with stall_i=1 for 3 cycles -> ctr 01 x3, then 00 with instr_o=0x00500093, pc_o unchanged.
REQ-036 redirect_i to 0x200 while WAIT with 3-cycle latency -> stale response dropped, next request 0x200, no ctr=00 for the stale word.
REQ-037 redirect coincident with imem_rvalid_i -> ctr 10, next request at redirect_pc_i the following cycle.
REQ-038 IF_STATIC_PRED_EN, pc=0x120, instr 0xFE000EE3 (beq, offset -4) -> next request 0x11C, br_pred_o=1; without macro -> 0x124, br_pred_o=0.
REQ-039 n_rst pulsed low mid-WAIT -> outputs at reset values immediately; late response ignored; fetch restarts at RESET_PC.
